// File: rtl/rail_pwr_responder.sv
// Rail-side enable/power-good responder: drives the load switch, qualifies PG, latches faults.
// Outputs are registered from the next state (1-cycle latency from iEN; PG_DEBOUNCE+3 from raw PG).
module rail_pwr_responder #(
  parameter int unsigned RAMP_TIMEOUT_MS  = 20,
  parameter int unsigned PG_DEBOUNCE      = 4,
  parameter int unsigned OFF_DISCHARGE_MS = 10
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iTick_1ms,
  input  logic       iEN,
  input  logic       iPG_RAW,
  input  logic       iFault_Clear,
  output logic       oRail_EN,
  output logic       oDischarge_EN,
  output logic       oPWRGD,
  output logic       oFault,
  output logic [1:0] oFault_Code,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_ON     = 3'd2,
    ST_DISCHG = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [7:0]  DB_LIM   = 8'(PG_DEBOUNCE);
  localparam logic [15:0] RAMP_LIM = 16'(RAMP_TIMEOUT_MS);
  localparam logic [15:0] DIS_LIM  = 16'(OFF_DISCHARGE_MS);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  code_nxt;
  logic        pg_meta;
  logic        pg_s;
  logic        pg_filt;
  logic [7:0]  db_cnt;
  logic [15:0] ms_cnt;
  logic [15:0] ms_inc;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
      pg_filt <= 1'b0;
      db_cnt  <= 8'd0;
    end else begin
      pg_meta <= iPG_RAW;
      pg_s    <= pg_meta;
      if (pg_s != pg_filt) begin
        if (db_cnt + 8'd1 >= DB_LIM) begin
          pg_filt <= pg_s;
          db_cnt  <= 8'd0;
        end else begin
          db_cnt  <= db_cnt + 8'd1;
        end
      end else begin
        db_cnt <= 8'd0;
      end
    end
  end

  // Tick-inclusive count so a limit is met on the edge that samples the final tick.
  assign ms_inc = (iTick_1ms && (ms_cnt != 16'hFFFF)) ? ms_cnt + 16'd1 : ms_cnt;

  always_comb begin
    state_nxt = ST_OFF;
    code_nxt  = 2'd0;
    case (state)
      ST_OFF: begin
        if (iEN && pg_filt) begin
          state_nxt = ST_FAULT;
          code_nxt  = 2'd3;
        end else if (iEN) begin
          state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (!iEN) begin
          state_nxt = ST_DISCHG;
        end else if (pg_filt) begin
          state_nxt = ST_ON;
        end else if (ms_inc >= RAMP_LIM) begin
          state_nxt = ST_FAULT;
          code_nxt  = 2'd1;
        end else begin
          state_nxt = ST_RAMP;
        end
      end
      ST_ON: begin
        if (!iEN) begin
          state_nxt = ST_DISCHG;
        end else if (!pg_filt) begin
          state_nxt = ST_FAULT;
          code_nxt  = 2'd2;
        end else begin
          state_nxt = ST_ON;
        end
      end
      ST_DISCHG: begin
        // iEN is deliberately ignored: this is the enforced minimum off time.
        if ((ms_inc >= DIS_LIM) && !pg_filt) state_nxt = ST_OFF;
        else                                 state_nxt = ST_DISCHG;
      end
      ST_FAULT: begin
        if (iFault_Clear && !iEN) begin
          state_nxt = ST_OFF;
        end else begin
          state_nxt = ST_FAULT;
          code_nxt  = oFault_Code;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state         <= ST_OFF;
      ms_cnt        <= 16'd0;
      oRail_EN      <= 1'b0;
      oDischarge_EN <= 1'b0;
      oPWRGD        <= 1'b0;
      oFault        <= 1'b0;
      oFault_Code   <= 2'd0;
    end else begin
      state         <= state_nxt;
      ms_cnt        <= (state_nxt != state) ? 16'd0 : ms_inc;
      oRail_EN      <= (state_nxt == ST_RAMP) || (state_nxt == ST_ON);
      oDischarge_EN <= (state_nxt == ST_DISCHG) || (state_nxt == ST_FAULT);
      oPWRGD        <= (state_nxt == ST_ON);
      oFault        <= (state_nxt == ST_FAULT);
      oFault_Code   <= code_nxt;
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_rail_pwr_responder.sv
// Directed bench for rail_pwr_responder with default parameters (timeout 20, debounce 4, discharge 10).
module tb_rail_pwr_responder;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iTick_1ms;
  logic       iEN;
  logic       iPG_RAW;
  logic       iFault_Clear;
  logic       oRail_EN;
  logic       oDischarge_EN;
  logic       oPWRGD;
  logic       oFault;
  logic [1:0] oFault_Code;
  logic [2:0] oState;

  int checks = 0;
  int errors = 0;

  rail_pwr_responder #(
    .RAMP_TIMEOUT_MS (20),
    .PG_DEBOUNCE     (4),
    .OFF_DISCHARGE_MS(10)
  ) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iTick_1ms    (iTick_1ms),
    .iEN          (iEN),
    .iPG_RAW      (iPG_RAW),
    .iFault_Clear (iFault_Clear),
    .oRail_EN     (oRail_EN),
    .oDischarge_EN(oDischarge_EN),
    .oPWRGD       (oPWRGD),
    .oFault       (oFault),
    .oFault_Code  (oFault_Code),
    .oState       (oState)
  );

  always #5 iClk = ~iClk;

  // Advance n edges; inputs set after return are sampled by the next edge.
  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      iTick_1ms = 1'b1;
      step(1);
      iTick_1ms = 1'b0;
      step(1);
    end
  endtask

  task automatic test_reset;
    iRst_n = 1'b0; iTick_1ms = 1'b0; iEN = 1'b0; iPG_RAW = 1'b0; iFault_Clear = 1'b0;
    step(2);
    checks++; if ({oRail_EN, oDischarge_EN, oPWRGD, oFault, oFault_Code, oState} !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000000", {oRail_EN, oDischarge_EN, oPWRGD, oFault, oFault_Code, oState}); end
    iRst_n = 1'b1;
    step(2);
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL reset_release_state: got %0d want 0", oState); end
  endtask

  task automatic test_normal_cycle;
    iEN = 1'b1;
    step(1);
    checks++; if (oRail_EN !== 1'b1 || oState !== 3'd1) begin
      errors++; $display("FAIL nc_rail_en: rail=%b state=%0d want 1/1", oRail_EN, oState); end
    tick_n(5);
    iPG_RAW = 1'b1;
    step(6);
    checks++; if (oPWRGD !== 1'b0 || oState !== 3'd1) begin
      errors++; $display("FAIL nc_pwrgd_early: pwrgd=%b state=%0d want 0/1", oPWRGD, oState); end
    step(1);
    checks++; if (oPWRGD !== 1'b1 || oState !== 3'd2 || oRail_EN !== 1'b1) begin
      errors++; $display("FAIL nc_pwrgd_on: pwrgd=%b state=%0d rail=%b want 1/2/1", oPWRGD, oState, oRail_EN); end
    iEN = 1'b0; iPG_RAW = 1'b0;
    step(1);
    checks++; if ({oPWRGD, oRail_EN, oDischarge_EN} !== 3'b001 || oState !== 3'd3) begin
      errors++; $display("FAIL nc_shutdown: pwrgd/rail/dis=%b state=%0d want 001/3", {oPWRGD, oRail_EN, oDischarge_EN}, oState); end
    tick_n(9);
    checks++; if (oState !== 3'd3 || oDischarge_EN !== 1'b1) begin
      errors++; $display("FAIL nc_dischg_min: state=%0d dis=%b want 3/1", oState, oDischarge_EN); end
    iTick_1ms = 1'b1; step(1); iTick_1ms = 1'b0;
    checks++; if (oState !== 3'd0 || oDischarge_EN !== 1'b0) begin
      errors++; $display("FAIL nc_dischg_exit: state=%0d dis=%b want 0/0", oState, oDischarge_EN); end
  endtask

  task automatic test_ramp_timeout;
    iEN = 1'b1;
    step(1);
    tick_n(19);
    checks++; if (oState !== 3'd1) begin errors++; $display("FAIL rt_before_timeout: state=%0d want 1", oState); end
    iTick_1ms = 1'b1; step(1); iTick_1ms = 1'b0;
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd1 || oFault !== 1'b1 || oRail_EN !== 1'b0 || oDischarge_EN !== 1'b1) begin
      errors++; $display("FAIL rt_fault: state=%0d code=%0d fault=%b rail=%b dis=%b want 4/1/1/0/1",
                         oState, oFault_Code, oFault, oRail_EN, oDischarge_EN); end
    iFault_Clear = 1'b1;
    step(3);
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd1) begin
      errors++; $display("FAIL rt_clear_ignored: state=%0d code=%0d want 4/1", oState, oFault_Code); end
    iEN = 1'b0;
    step(1);
    checks++; if (oState !== 3'd0 || oFault !== 1'b0 || oFault_Code !== 2'd0 || oDischarge_EN !== 1'b0) begin
      errors++; $display("FAIL rt_clear: state=%0d fault=%b code=%0d dis=%b want 0/0/0/0", oState, oFault, oFault_Code, oDischarge_EN); end
    iFault_Clear = 1'b0;
  endtask

  task automatic test_pg_loss;
    iEN = 1'b1;
    step(1);
    iPG_RAW = 1'b1;
    step(7);
    checks++; if (oState !== 3'd2) begin errors++; $display("FAIL pl_on: state=%0d want 2", oState); end
    iPG_RAW = 1'b0; step(3); iPG_RAW = 1'b1;
    step(10);
    checks++; if (oState !== 3'd2 || oPWRGD !== 1'b1) begin
      errors++; $display("FAIL pl_glitch: state=%0d pwrgd=%b want 2/1", oState, oPWRGD); end
    iPG_RAW = 1'b0;
    step(6);
    checks++; if (oPWRGD !== 1'b1) begin errors++; $display("FAIL pl_pwrgd_early: pwrgd=%b want 1", oPWRGD); end
    step(1);
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd2 || oPWRGD !== 1'b0) begin
      errors++; $display("FAIL pl_fault: state=%0d code=%0d pwrgd=%b want 4/2/0", oState, oFault_Code, oPWRGD); end
    step(3);
    iPG_RAW = 1'b1;
    step(10);
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd2) begin
      errors++; $display("FAIL pl_code_held: state=%0d code=%0d want 4/2", oState, oFault_Code); end
    iEN = 1'b0; iFault_Clear = 1'b1;
    step(1);
    iFault_Clear = 1'b0; iPG_RAW = 1'b0;
    step(8);
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL pl_cleared: state=%0d want 0", oState); end
  endtask

  task automatic test_stuck_pg;
    iPG_RAW = 1'b1;
    step(20);
    iEN = 1'b1;
    step(1);
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd3 || oRail_EN !== 1'b0) begin
      errors++; $display("FAIL sp_fault: state=%0d code=%0d rail=%b want 4/3/0", oState, oFault_Code, oRail_EN); end
    step(5);
    checks++; if (oRail_EN !== 1'b0) begin errors++; $display("FAIL sp_rail_off: rail=%b want 0", oRail_EN); end
    iEN = 1'b0; iFault_Clear = 1'b1;
    step(1);
    iFault_Clear = 1'b0; iPG_RAW = 1'b0;
    step(8);
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL sp_cleared: state=%0d want 0", oState); end
  endtask

  task automatic test_simultaneous;
    iEN = 1'b1;
    step(1);
    iPG_RAW = 1'b1;
    step(7);
    iPG_RAW = 1'b0;
    step(6);
    checks++; if (oState !== 3'd2) begin errors++; $display("FAIL si_still_on: state=%0d want 2", oState); end
    iEN = 1'b0;
    step(1);
    checks++; if (oState !== 3'd3 || oFault_Code !== 2'd0 || oFault !== 1'b0) begin
      errors++; $display("FAIL si_dischg: state=%0d code=%0d fault=%b want 3/0/0", oState, oFault_Code, oFault); end
    iEN = 1'b1;
    step(3);
    checks++; if (oState !== 3'd3 || oRail_EN !== 1'b0) begin
      errors++; $display("FAIL si_en_ignored: state=%0d rail=%b want 3/0", oState, oRail_EN); end
    iEN = 1'b0;
    tick_n(9);
    checks++; if (oState !== 3'd3) begin errors++; $display("FAIL si_dischg_hold: state=%0d want 3", oState); end
    iTick_1ms = 1'b1; step(1); iTick_1ms = 1'b0;
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL si_off: state=%0d want 0", oState); end
  endtask

  task automatic test_reset_mid_on;
    iEN = 1'b1;
    step(1);
    iPG_RAW = 1'b1;
    step(7);
    checks++; if (oState !== 3'd2) begin errors++; $display("FAIL rm_on: state=%0d want 2", oState); end
    iRst_n = 1'b0;
    step(1);
    checks++; if ({oRail_EN, oDischarge_EN, oPWRGD, oFault, oFault_Code, oState} !== 8'd0) begin
      errors++; $display("FAIL rm_outputs: got %b want 00000000", {oRail_EN, oDischarge_EN, oPWRGD, oFault, oFault_Code, oState}); end
    iRst_n = 1'b1; iEN = 1'b0;
    step(10);
    iEN = 1'b1;
    step(1);
    checks++; if (oState !== 3'd4 || oFault_Code !== 2'd3 || oRail_EN !== 1'b0) begin
      errors++; $display("FAIL rm_stuck: state=%0d code=%0d rail=%b want 4/3/0", oState, oFault_Code, oRail_EN); end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ramp_timeout();
    test_pg_loss();
    test_stuck_pg();
    test_simultaneous();
    test_reset_mid_on();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rail_pwr_responder.md
# rail_pwr_responder

Rail-side responder for the master power sequencer's enable/power-good handshake. It receives one rail enable (for example the fan 12 V AUX, device or node 12 V enable) and drives the load-switch enable. It qualifies the regulator's raw power-good and returns a clean, registered power-good to the sequencer. It also latches ramp-timeout, power-good-loss and stuck-power-good faults, and controls an output discharge path on every turn-off.

## Interface
- RAMP_TIMEOUT_MS, 20: ms ticks allowed in RAMP for qualified PG to rise; 1..65535.
- PG_DEBOUNCE, 4: consecutive iClk cycles a synchronized PG level must hold before the filtered PG changes; 1..255.
- OFF_DISCHARGE_MS, 10: minimum ms ticks spent in DISCHG; 1..65535.

Ports:
- iClk  in  1  module clock. One clock only.
- iRst_n  in  1  synchronous, active-low reset.
- iTick_1ms  in  1  single-cycle strobe in the iClk domain, once per ms.
- iEN  in  1  rail enable from the sequencer, synchronous to iClk.
- iPG_RAW  in  1  raw regulator power-good, asynchronous.
- iFault_Clear  in  1  level input; clears a latched fault.
- oRail_EN  out  1  load-switch enable.
- oDischarge_EN  out  1  output discharge FET enable.
- oPWRGD  out  1  qualified power-good to the sequencer.
- oFault  out  1  latched fault flag.
- oFault_Code  out  2  fault code: 0 none, 1 ramp timeout, 2 PG lost while ON, 3 PG already high at enable.
- oState  out  3  debug state: OFF=0, RAMP=1, ON=2, DISCHG=3, FAULT=4.

## Operation
- iPG_RAW passes through a 2-flop synchronizer to give pg_s.
- pg_filt changes to pg_s after pg_s has differed from pg_filt on PG_DEBOUNCE consecutive edges. Any agreement between them resets the debounce counter.
- ms_cnt is 16 bits and saturating. It clears on every state entry and increments on each iTick_1ms.
- All outputs are registered Moore outputs decoded from the next state. They change on the same edge as the state register.
- OFF: all outputs 0.
  - iEN=1 and pg_filt=0 → RAMP.
  - iEN=1 and pg_filt=1 → FAULT, code 3.
- RAMP: oRail_EN=1. Priority order:
  - iEN=0 → DISCHG.
  - else pg_filt=1 → ON.
  - else ms_cnt reaching RAMP_TIMEOUT_MS → FAULT, code 1.
- ON: oRail_EN=1, oPWRGD=1.
  - iEN=0 → DISCHG. This takes priority over a simultaneous PG loss (normal shutdown).
  - else pg_filt=0 → FAULT, code 2.
- DISCHG: oRail_EN=0, oDischarge_EN=1.
  - Exit to OFF once ms_cnt ≥ OFF_DISCHARGE_MS and pg_filt=0.
  - iEN is ignored here; this enforces the minimum off time.
  - If PG stays high, the block waits indefinitely and raises no fault.
- FAULT: oRail_EN=0, oDischarge_EN=1, oFault=1, oFault_Code held.
  - iFault_Clear=1 and iEN=0 → OFF, which clears oFault and the code on the same edge.
  - iFault_Clear while iEN=1 is ignored.
  - Further PG activity does not change the code; the first fault wins.
- State encodings 5–7 are illegal and return to OFF on the next edge with all outputs 0.

## Timing
- Reset (iRst_n sampled low):
  - All outputs 0, state OFF.
  - Synchronizer, pg_filt, debounce counter and ms_cnt all 0.
  - Applies even mid-RAMP or mid-ON: oRail_EN drops at the sampling edge, with no discharge phase.
- iEN rise → oRail_EN rises at the first edge sampling iEN=1 in OFF (1-cycle latency).
- iPG_RAW rise in RAMP (stable) → oPWRGD=1 at edge PG_DEBOUNCE+3 after the first edge sampling iPG_RAW=1.
  - The same latency applies to PG loss → FAULT in ON.
- A PG glitch shorter than PG_DEBOUNCE cycles after synchronization produces no state change.
- iEN fall in ON → at the sampling edge, oPWRGD=0, oRail_EN=0 and oDischarge_EN=1, all on the same edge.
- Ramp timeout: FAULT is entered at the edge sampling the RAMP_TIMEOUT_MS-th tick counted in RAMP.
  - A pg_filt rise on that same edge wins, giving ON.
- DISCHG → OFF no earlier than the edge sampling the OFF_DISCHARGE_MS-th tick.

## Test plan
- Normal cycle, PG_DEBOUNCE=4: iEN=1, iPG_RAW high 5 ms later → oRail_EN rises 1 cycle after iEN; oPWRGD rises 7 cycles after PG. Then iEN=0 → DISCHG for ≥10 ticks with oDischarge_EN=1, then OFF.
- Ramp timeout: iEN=1, PG never rises → FAULT with code 1 on tick 20. Check oRail_EN=0 and oDischarge_EN=1. iFault_Clear=1 with iEN=1 → stays in FAULT; then iEN=0 → OFF.
- PG loss in ON: drop iPG_RAW for 3 cycles → no change. Drop it for 10 cycles → FAULT with code 2, with oPWRGD falling 7 cycles after the drop.
- Stuck PG: iPG_RAW=1 held for 20 cycles while OFF, then iEN=1 → FAULT with code 3; oRail_EN never asserts.
- Simultaneous events:
  - In ON, iEN=0 on the same edge pg_filt falls → DISCHG, code stays 0.
  - In DISCHG, iEN re-pulsed → ignored until OFF.
- Reset mid-ON: iRst_n low for 1 cycle → all outputs 0 at that edge. After release with iEN=1 and PG high → FAULT with code 3.
